// File: rtl/see_upset_gen_pkg.sv
// Shared constants and types for the transient-upset generator family.
package see_upset_gen_pkg;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
    // Replacement value for a zero seed, which would lock the LFSR
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HIT  = 2'd2,
        ST_COOL = 2'd3
    } upset_state_e;

    // A zero seed is never usable; substitute the default
    function automatic logic [31:0] fix_seed(input logic [31:0] seed);
        return (seed == 32'h0000_0000) ? LFSR_DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/see_lfsr.sv
// Right-shifting Galois LFSR with hold enable; zero seeds are replaced by 1.
module see_lfsr #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h8020_0003,
    parameter logic [WIDTH-1:0] SEED  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] lfsr
);

    localparam logic [WIDTH-1:0] ZERO_L = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_L  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_L = (SEED == ZERO_L) ? ONE_L : SEED;

    logic [WIDTH-1:0] lfsr_r;
    logic [WIDTH-1:0] lfsr_next_s;

    // Next value: shift right, fold taps in when the outgoing bit is 1
    always_comb begin
        lfsr_next_s = {1'b0, lfsr_r[WIDTH-1:1]};
        if (lfsr_r[0]) begin
            lfsr_next_s = lfsr_next_s ^ TAPS;
        end else begin
            lfsr_next_s = lfsr_next_s;
        end
    end

    // State register: advances only while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED_L;
        end else if (en) begin
            lfsr_r <= lfsr_next_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign lfsr = lfsr_r;

endmodule

// File: rtl/see_upset_gen.sv
// Transient single-bit upset generator: LFSR-driven fire decision, target
// selection, duration and cooldown, producing registered per-word XOR masks.
// Index fields use lfsr[16 +: BW] and lfsr[24 +: NW], so W <= 65536, N <= 256.
module see_upset_gen
    import see_upset_gen_pkg::*;
#(
    parameter int          W     = 32,
    parameter int          N     = 1,
    parameter logic [31:0] SEED  = 32'h0000_0001,
    parameter int          GAP   = 4,
    parameter int          CNT_W = 16
) (
    input  logic             s_clk_i,
    input  logic             s_resetn_i,
    input  logic             s_en_i,
    input  logic [15:0]      s_rate_i,
    input  logic [7:0]       s_dur_i,
    input  logic             s_single_i,
    output logic [W-1:0]     s_upset_o [N],
    output logic             s_hit_o,
    output logic [CNT_W-1:0] s_count_o
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    // Limits widened by one bit so a power-of-two limit is representable
    localparam logic [BW:0]      W_LIM   = W[BW:0];
    localparam logic [NW:0]      N_LIM   = N[NW:0];
    localparam logic [GW-1:0]    GAP_L   = GAP[GW-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      lfsr_s;
    upset_state_e     state_r, state_next_s;
    logic [7:0]       dur_cnt_r, dur_next_s;
    logic [GW-1:0]    gap_cnt_r, gap_next_s;
    logic [BW-1:0]    bit_idx_r, bit_next_s, bit_raw_s, bit_sel_s, bit_use_s;
    logic [NW-1:0]    word_idx_r, word_next_s, word_raw_s, word_sel_s, word_use_s;
    logic             pending_r, pend_next_s;
    logic             hit_r, hit_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic             fire_s;
    logic             mask_on_s;
    logic [7:0]       dur_eff_s;
    logic [W-1:0]     onehot_s [N];
    logic [W-1:0]     upset_r  [N];

    see_lfsr #(
        .WIDTH (32),
        .TAPS  (LFSR_TAPS),
        .SEED  (fix_seed(SEED))
    ) u_lfsr (
        .clk   (s_clk_i),
        .rst_n (s_resetn_i),
        .en    (s_en_i),
        .lfsr  (lfsr_s)
    );

    assign bit_raw_s  = lfsr_s[16 +: BW];
    assign word_raw_s = lfsr_s[24 +: NW];
    assign dur_eff_s  = (s_dur_i == 8'd0) ? 8'd1 : s_dur_i;
    assign fire_s     = (lfsr_s[15:0] < s_rate_i) || pending_r || s_single_i;

    // Fold out-of-range index fields back into range with one subtraction
    always_comb begin
        if ({1'b0, bit_raw_s} >= W_LIM) begin
            bit_sel_s = bit_raw_s - W_LIM[BW-1:0];
        end else begin
            bit_sel_s = bit_raw_s;
        end
        if ({1'b0, word_raw_s} >= N_LIM) begin
            word_sel_s = word_raw_s - N_LIM[NW-1:0];
        end else begin
            word_sel_s = word_raw_s;
        end
    end

    // Use fresh indices on the fire edge, latched indices while the upset lasts
    always_comb begin
        if (state_r == ST_WAIT) begin
            bit_use_s  = bit_sel_s;
            word_use_s = word_sel_s;
        end else begin
            bit_use_s  = bit_idx_r;
            word_use_s = word_idx_r;
        end
    end

    // One-hot decode of the target word/bit
    always_comb begin
        for (int k = 0; k < N; k++) begin
            for (int b = 0; b < W; b++) begin
                onehot_s[k][b] = (word_use_s == NW'(k)) && (bit_use_s == BW'(b));
            end
        end
    end

    // Next-state and datapath control for the upset sequencer
    always_comb begin
        state_next_s = state_r;
        dur_next_s   = dur_cnt_r;
        gap_next_s   = gap_cnt_r;
        bit_next_s   = bit_idx_r;
        word_next_s  = word_idx_r;
        pend_next_s  = pending_r;
        hit_next_s   = 1'b0;
        count_next_s = count_r;
        mask_on_s    = 1'b0;
        if (!s_en_i) begin
            state_next_s = ST_IDLE;
            dur_next_s   = 8'd0;
            gap_next_s   = {GW{1'b0}};
            pend_next_s  = 1'b0;
        end else begin
            pend_next_s = pending_r | s_single_i;
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_WAIT;
                end
                ST_WAIT: begin
                    if (fire_s) begin
                        state_next_s = ST_HIT;
                        bit_next_s   = bit_sel_s;
                        word_next_s  = word_sel_s;
                        dur_next_s   = dur_eff_s;
                        pend_next_s  = 1'b0;
                        hit_next_s   = 1'b1;
                        mask_on_s    = 1'b1;
                        if (count_r != CNT_MAX) begin
                            count_next_s = count_r + CNT_W'(1);
                        end else begin
                            count_next_s = count_r;
                        end
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end
                ST_HIT: begin
                    if (dur_cnt_r <= 8'd1) begin
                        dur_next_s = 8'd0;
                        if (GAP == 0) begin
                            state_next_s = ST_WAIT;
                            gap_next_s   = {GW{1'b0}};
                        end else begin
                            state_next_s = ST_COOL;
                            gap_next_s   = GAP_L;
                        end
                    end else begin
                        dur_next_s = dur_cnt_r - 8'd1;
                        mask_on_s  = 1'b1;
                    end
                end
                ST_COOL: begin
                    if (gap_cnt_r <= GW'(1)) begin
                        state_next_s = ST_WAIT;
                        gap_next_s   = {GW{1'b0}};
                    end else begin
                        gap_next_s = gap_cnt_r - GW'(1);
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state, counters and latched target indices
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_r    <= ST_IDLE;
            dur_cnt_r  <= 8'd0;
            gap_cnt_r  <= {GW{1'b0}};
            bit_idx_r  <= {BW{1'b0}};
            word_idx_r <= {NW{1'b0}};
            pending_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            dur_cnt_r  <= dur_next_s;
            gap_cnt_r  <= gap_next_s;
            bit_idx_r  <= bit_next_s;
            word_idx_r <= word_next_s;
            pending_r  <= pend_next_s;
        end
    end

    // Registered outputs: masks, first-cycle pulse, saturating counter
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            for (int k = 0; k < N; k++) begin
                upset_r[k] <= {W{1'b0}};
            end
            hit_r   <= 1'b0;
            count_r <= {CNT_W{1'b0}};
        end else begin
            for (int k = 0; k < N; k++) begin
                upset_r[k] <= mask_on_s ? onehot_s[k] : {W{1'b0}};
            end
            hit_r   <= hit_next_s;
            count_r <= count_next_s;
        end
    end

    assign s_upset_o = upset_r;
    assign s_hit_o   = hit_r;
    assign s_count_o = count_r;

endmodule

// File: tb/tb_see_upset_gen.sv
// Directed self-checking bench for see_upset_gen (W=24, N=3, GAP=2, CNT_W=4, zero seed).
module tb_see_upset_gen;

    localparam int          W       = 24;
    localparam int          N       = 3;
    localparam int          GAP     = 2;
    localparam int          CNT_W   = 4;
    localparam logic [31:0] SEED    = 32'h0000_0000;
    localparam int          SPACING = 1 + GAP + 1;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [15:0]      rate;
    logic [7:0]       dur;
    logic             single;
    logic [W-1:0]     upset [N];
    logic             hit;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    logic [31:0] model_lfsr;
    logic [31:0] lfsr_used;
    int          cyc;
    int          hit_total;
    int          run_len;
    int          last_run;
    int          prev_cyc;
    bit          have_prev;
    bit          chk_spacing;
    logic [71:0] cur_flat;
    logic [71:0] hit_map;
    logic [71:0] flat_m;
    logic [71:0] all_pos;

    see_upset_gen #(
        .W(W), .N(N), .SEED(SEED), .GAP(GAP), .CNT_W(CNT_W)
    ) dut (
        .s_clk_i    (clk),
        .s_resetn_i (rst_n),
        .s_en_i     (en),
        .s_rate_i   (rate),
        .s_dur_i    (dur),
        .s_single_i (single),
        .s_upset_o  (upset),
        .s_hit_o    (hit),
        .s_count_o  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        if (l[0]) return (l >> 1) ^ 32'h8020_0003;
        else      return l >> 1;
    endfunction

    function automatic logic [71:0] exp_flat(input logic [31:0] l);
        logic [4:0]  b;
        logic [1:0]  w;
        logic [71:0] one;
        b = l[20:16];
        if (b >= 5'd24) b = b - 5'd24;
        w = l[25:24];
        if (w >= 2'd3) w = w - 2'd3;
        one = 72'd1;
        return one << (int'(w) * 24 + int'(b));
    endfunction

    function automatic logic [71:0] flat_of();
        return {upset[2], upset[1], upset[0]};
    endfunction

    function automatic int sat_cnt(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Golden LFSR: tracks the DUT generator and remembers the value used at each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_lfsr <= 32'h0000_0001;
            lfsr_used  <= 32'h0000_0001;
            cyc        <= 0;
        end else begin
            lfsr_used <= model_lfsr;
            cyc       <= cyc + 1;
            if (en) model_lfsr <= lfsr_step(model_lfsr);
        end
    end

    // Output monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (!rst_n) begin
            hit_total = 0;
            run_len   = 0;
            last_run  = 0;
            have_prev = 1'b0;
            cur_flat  = 72'd0;
        end else begin
            flat_m = flat_of();
            check_eq("onehot", 128'($countones(flat_m) <= 1), 128'd1);
            if (hit) begin
                hit_total++;
                hit_map = hit_map | flat_m;
                check_eq("hit_pos", flat_m, exp_flat(lfsr_used));
                check_eq("hit_count", count, sat_cnt(hit_total));
                if (chk_spacing && have_prev) check_eq("spacing", cyc - prev_cyc, SPACING);
                prev_cyc  = cyc;
                have_prev = 1'b1;
                cur_flat  = flat_m;
            end else if (flat_m != 72'd0) begin
                check_eq("hold_pos", flat_m, cur_flat);
            end
            if (flat_m != 72'd0) begin
                run_len++;
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; rate = 16'd0; dur = 8'd0; single = 1'b0;
        chk_spacing = 1'b0;
        hit_map = 72'd0;
        all_pos = {72{1'b1}};
        step(3);
        check_eq("rst_mask", flat_of(), 72'd0);
        check_eq("rst_hit", hit, 1'b0);
        check_eq("rst_count", count, 4'd0);
        rst_n = 1'b1;
        step(1);

        // Rate 0, no single: nothing fires
        en = 1'b1;
        step(1000);
        check_eq("quiet_hits", hit_total, 0);
        check_eq("quiet_count", count, 4'd0);
        check_eq("quiet_mask", flat_of(), 72'd0);

        // One single pulse, duration 3
        dur = 8'd3; single = 1'b1;
        step(1);
        single = 1'b0;
        check_eq("single_lat", hit, 1'b1);
        step(8);
        check_eq("single_len", last_run, 3);
        check_eq("single_count", count, 4'd1);
        check_eq("single_hits", hit_total, 1);

        // Duration sampled at the fire edge only
        dur = 8'd5; single = 1'b1;
        step(1);
        single = 1'b0; dur = 8'd1;
        step(10);
        check_eq("dur_sampled", last_run, 5);
        check_eq("dur_count", count, 4'd2);

        // Pulses during HIT are kept and collapse into one
        dur = 8'd4; single = 1'b1;
        step(1);
        single = 1'b0;
        step(1);
        single = 1'b1;
        step(1);
        single = 1'b0;
        step(1);
        single = 1'b1;
        step(1);
        single = 1'b0;
        step(20);
        check_eq("pend_hits", hit_total, 4);
        check_eq("pend_count", count, 4'd4);
        check_eq("pend_len", last_run, 4);

        // Enable dropped mid-HIT; pending cleared; LFSR frozen
        dur = 8'd10; single = 1'b1;
        step(1);
        single = 1'b0;
        step(1);
        single = 1'b1;
        step(1);
        single = 1'b0;
        step(1);
        en = 1'b0;
        step(1);
        check_eq("drop_mask", flat_of(), 72'd0);
        check_eq("drop_len", last_run, 4);
        step(5);
        en = 1'b1;
        step(10);
        check_eq("drop_pend_clr", hit_total, 5);
        single = 1'b1;
        step(1);
        single = 1'b0;
        check_eq("resume_hit", hit, 1'b1);
        step(15);
        check_eq("resume_len", last_run, 10);
        check_eq("resume_count", count, 4'd6);

        // Continuous firing, duration 0 treated as 1
        dur = 8'd0; rate = 16'hFFFF;
        have_prev = 1'b0; chk_spacing = 1'b1;
        step(20000);
        chk_spacing = 1'b0;
        rate = 16'd0;
        step(10);
        check_eq("cont_len", last_run, 1);
        check_eq("sat_count", count, 4'hF);
        check_eq("coverage", hit_map, all_pos);

        // Asynchronous reset mid-HIT
        dur = 8'd10; single = 1'b1;
        step(1);
        single = 1'b0;
        step(2);
        check_eq("pre_rst_mask", flat_of() != 72'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_mask", flat_of(), 72'd0);
        check_eq("arst_count", count, 4'd0);
        check_eq("arst_hit", hit, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check_eq("post_rst_mask", flat_of(), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
